// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared opcodes, field positions, FSM states and control decode for the decode stage
package decode_stage_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_W   = 5;
  localparam int REG_W   = 3;
  localparam int SH_W    = 5;

  localparam int OPC_LSB = 11;
  localparam int RS_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 0;

  localparam logic [OPC_W-1:0] OP_NOP    = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDM    = 5'b11000;
  localparam logic [OPC_W-1:0] OP_LDD    = 5'b11001;
  localparam logic [OPC_W-1:0] OP_STD    = 5'b11010;
  localparam logic [OPC_W-1:0] OP_ALU_HI = 5'b10111;

  typedef enum logic {
    NORMAL   = 1'b0,
    WAIT_IMM = 1'b1
  } state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic has_imm;
  } ctrl_t;

  function automatic logic [OPC_W-1:0] op_of(input logic [INSTR_W-1:0] w);
    return w[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [REG_W-1:0] rs_of(input logic [INSTR_W-1:0] w);
    return w[RS_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rd_of(input logic [INSTR_W-1:0] w);
    return w[RD_LSB +: REG_W];
  endfunction

  function automatic logic [SH_W-1:0] sh_of(input logic [INSTR_W-1:0] w);
    return w[SH_LSB +: SH_W];
  endfunction

  // Jump opcodes (11011..11111) decode to no controls; they are resolved elsewhere.
  function automatic ctrl_t ctrl_decode(input logic [OPC_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_NOP: c = '0;
      OP_LDM: begin
        c.has_imm   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_LDD: begin
        c.has_imm   = 1'b1;
        c.mem_read  = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_STD: begin
        c.has_imm   = 1'b1;
        c.mem_write = 1'b1;
      end
      default: c.reg_write = (op <= OP_ALU_HI);
    endcase
    return c;
  endfunction

  function automatic logic is_imm_class(input logic [OPC_W-1:0] op);
    ctrl_t c;
    c = ctrl_decode(op);
    return c.has_imm;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch-to-decode word handshake
interface decode_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32
);
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc_next;
  logic              if_ready;

  modport master (output if_valid, if_instr, if_pc_next, input if_ready);
  modport slave  (input if_valid, if_instr, if_pc_next, output if_ready);
endinterface

// File: rtl/decode_stage_register_file.sv
// rtl/decode_stage_register_file.sv - 8x16 register file, one write port, two bypassed read ports
module register_file #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Write-through so a reader in the same cycle as a writeback sees the new value.
  always_comb begin
    rs_data = regs[rs_addr];
    rd_data = regs[rd_addr];
    if (wr_en && (wr_addr == rs_addr)) rs_data = wr_data;
    if (wr_en && (wr_addr == rd_addr)) rd_data = wr_data;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage: pairs immediates, reads operands, registers the ID/EX bundle
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  decode_stage_if.slave     fetch,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_valid,
  output logic [4:0]        id_opcode,
  output logic [2:0]        id_rs,
  output logic [2:0]        id_rd,
  output logic [4:0]        id_shamt,
  output logic [DATA_W-1:0] id_rs_val,
  output logic [DATA_W-1:0] id_rd_val,
  output logic [DATA_W-1:0] id_imm,
  output logic [ADDR_W-1:0] id_pc_next,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write,
  output logic              id_has_imm
);

  state_t            state;
  logic [DATA_W-1:0] pend_instr;
  logic [ADDR_W-1:0] pend_pc;

  logic              consume;
  logic              in_is_imm;
  logic              load_instr;
  logic              load_bubble;
  logic [DATA_W-1:0] src_instr;
  ctrl_t             src_ctrl;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rd_val;

  assign fetch.if_ready = ~stall;

  always_comb begin
    consume     = fetch.if_valid & ~stall & ~flush;
    in_is_imm   = is_imm_class(op_of(fetch.if_instr));
    // In WAIT_IMM the instruction being emitted is the pending one, not the word on the bus.
    src_instr   = (state == WAIT_IMM) ? pend_instr : fetch.if_instr;
    src_ctrl    = ctrl_decode(op_of(src_instr));
    load_instr  = consume & ~((state == NORMAL) & in_is_imm);
    load_bubble = flush | (~stall & ~load_instr);
  end

  register_file #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data),
    .rs_addr (rs_of(src_instr)),
    .rs_data (rs_val),
    .rd_addr (rd_of(src_instr)),
    .rd_data (rd_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= NORMAL;
      pend_instr   <= '0;
      pend_pc      <= '0;
      id_valid     <= 1'b0;
      id_opcode    <= '0;
      id_rs        <= '0;
      id_rd        <= '0;
      id_shamt     <= '0;
      id_rs_val    <= '0;
      id_rd_val    <= '0;
      id_imm       <= '0;
      id_pc_next   <= '0;
      id_reg_write <= 1'b0;
      id_mem_read  <= 1'b0;
      id_mem_write <= 1'b0;
      id_has_imm   <= 1'b0;
    end else begin
      if (flush) begin
        state      <= NORMAL;
        pend_instr <= '0;
        pend_pc    <= '0;
      end else if (consume) begin
        if ((state == NORMAL) && in_is_imm) begin
          state      <= WAIT_IMM;
          pend_instr <= fetch.if_instr;
          pend_pc    <= fetch.if_pc_next;
        end else begin
          state <= NORMAL;
        end
      end

      if (load_bubble) begin
        id_valid     <= 1'b0;
        id_opcode    <= '0;
        id_rs        <= '0;
        id_rd        <= '0;
        id_shamt     <= '0;
        id_rs_val    <= '0;
        id_rd_val    <= '0;
        id_imm       <= '0;
        id_pc_next   <= '0;
        id_reg_write <= 1'b0;
        id_mem_read  <= 1'b0;
        id_mem_write <= 1'b0;
        id_has_imm   <= 1'b0;
      end else if (load_instr) begin
        id_valid     <= 1'b1;
        id_opcode    <= op_of(src_instr);
        id_rs        <= rs_of(src_instr);
        id_rd        <= rd_of(src_instr);
        id_shamt     <= sh_of(src_instr);
        id_rs_val    <= rs_val;
        id_rd_val    <= rd_val;
        id_imm       <= (state == WAIT_IMM) ? fetch.if_instr : '0;
        id_pc_next   <= (state == WAIT_IMM) ? pend_pc : fetch.if_pc_next;
        id_reg_write <= src_ctrl.reg_write;
        id_mem_read  <= src_ctrl.mem_read;
        id_mem_write <= src_ctrl.mem_write;
        id_has_imm   <= src_ctrl.has_imm;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed table-driven bench for decode_stage
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        id_valid;
  logic [4:0]  id_opcode;
  logic [2:0]  id_rs;
  logic [2:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [15:0] id_rs_val;
  logic [15:0] id_rd_val;
  logic [15:0] id_imm;
  logic [31:0] id_pc_next;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_has_imm;

  int total = 0;
  int bad   = 0;

  decode_stage_if fetch ();

  decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch        (fetch),
    .stall        (stall),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rd        (id_rd),
    .id_shamt     (id_shamt),
    .id_rs_val    (id_rs_val),
    .id_rd_val    (id_rd_val),
    .id_imm       (id_imm),
    .id_pc_next   (id_pc_next),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .id_has_imm   (id_has_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [31:0] pc;
    logic [4:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rd;
    logic [4:0]  sh;
    logic [3:0]  ctrl;
    logic [15:0] rsv;
    logic [15:0] rdv;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] w, input logic [31:0] pc);
    fetch.if_valid   = v;
    fetch.if_instr   = w;
    fetch.if_pc_next = pc;
  endtask

  function automatic logic [3:0] ctrl_now();
    return {id_reg_write, id_mem_read, id_mem_write, id_has_imm};
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, id_valid, 1'b0);
    chk({name, "_fields"}, {id_opcode, id_rs, id_rd, id_shamt, id_imm, id_pc_next}, 64'h0);
    chk({name, "_ops"}, {id_rs_val, id_rd_val, ctrl_now()}, 64'h0);
  endtask

  initial begin
    vecs[0] = '{16'h0822, 32'h10, 5'h01, 3'd0, 3'd1, 5'd2,  4'b1000, 16'h1000, 16'h1111};
    vecs[1] = '{16'h0000, 32'h14, 5'h00, 3'd0, 3'd0, 5'd0,  4'b0000, 16'h1000, 16'h1000};
    vecs[2] = '{16'hBFDF, 32'h18, 5'h17, 3'd7, 3'd6, 5'd31, 4'b1000, 16'h1777, 16'h1666};
    vecs[3] = '{16'hDB85, 32'h1C, 5'h1B, 3'd3, 3'd4, 5'd5,  4'b0000, 16'h1333, 16'h1444};
    vecs[4] = '{16'hFD50, 32'h20, 5'h1F, 3'd5, 3'd2, 5'd16, 4'b0000, 16'h1555, 16'h1222};
    vecs[5] = '{16'h82E9, 32'h24, 5'h10, 3'd2, 3'd7, 5'd9,  4'b1000, 16'h1222, 16'h1777};

    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    wb_en = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    drive(1'b0, 16'h0, 32'h0);
    #1;
    chk_all_zero("reset");
    chk("reset_ready", fetch.if_ready, 1'b1);
    step();
    step();
    rst_n = 1'b1;

    // Preload r[i] = 0x1000 + i*0x111
    for (int i = 0; i < 8; i++) begin
      wb_en   = 1'b1;
      wb_addr = 3'(i);
      wb_data = 16'h1000 + 16'(i) * 16'h0111;
      step();
    end
    wb_en = 1'b0;

    for (int k = 0; k < 6; k++) begin
      drive(1'b1, vecs[k].instr, vecs[k].pc);
      step();
      chk($sformatf("vec%0d_valid", k), id_valid, 1'b1);
      chk($sformatf("vec%0d_fields", k), {id_opcode, id_rs, id_rd, id_shamt},
          {vecs[k].op, vecs[k].rs, vecs[k].rd, vecs[k].sh});
      chk($sformatf("vec%0d_ctrl", k), ctrl_now(), vecs[k].ctrl);
      chk($sformatf("vec%0d_ops", k), {id_rs_val, id_rd_val}, {vecs[k].rsv, vecs[k].rdv});
      chk($sformatf("vec%0d_imm_pc", k), {id_imm, id_pc_next}, {16'h0, vecs[k].pc});
    end

    drive(1'b0, 16'h0, 32'h0);
    step();
    chk("idle_bubble", id_valid, 1'b0);

    // LDM followed directly by its immediate
    drive(1'b1, 16'hC020, 32'h100);
    step();
    chk("ldm_bubble", id_valid, 1'b0);
    drive(1'b1, 16'hBEEF, 32'h102);
    step();
    chk("ldm_valid", id_valid, 1'b1);
    chk("ldm_fields", {id_opcode, id_rd, id_imm, id_pc_next}, {5'b11000, 3'd1, 16'hBEEF, 32'h100});
    chk("ldm_ctrl", ctrl_now(), 4'b1001);
    chk("ldm_rdval", id_rd_val, 16'h1111);

    // LDD with fetch gaps while waiting for the immediate
    drive(1'b1, 16'hC8E0, 32'h110);
    step();
    chk("ldd_bubble0", id_valid, 1'b0);
    drive(1'b0, 16'h0, 32'h0);
    step();
    chk("ldd_bubble1", id_valid, 1'b0);
    step();
    chk("ldd_bubble2", id_valid, 1'b0);
    drive(1'b1, 16'h5A5A, 32'h112);
    step();
    chk("ldd_valid", id_valid, 1'b1);
    chk("ldd_fields", {id_opcode, id_rd, id_imm, id_pc_next}, {5'b11001, 3'd7, 16'h5A5A, 32'h110});
    chk("ldd_ctrl", ctrl_now(), 4'b1101);
    chk("ldd_rdval", id_rd_val, 16'h1777);

    // STD: operands sampled on the immediate's edge, with a writeback to Rd in that cycle
    drive(1'b1, 16'hD140, 32'h120);
    step();
    drive(1'b1, 16'h0042, 32'h122);
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h7777;
    step();
    wb_en = 1'b0;
    chk("std_ctrl", ctrl_now(), 4'b0011);
    chk("std_imm_pc", {id_imm, id_pc_next}, {16'h0042, 32'h120});
    chk("std_ops", {id_rs_val, id_rd_val}, {16'h1111, 16'h7777});

    // Same-cycle writeback forwarding to Rs
    drive(1'b1, 16'h1260, 32'h130);
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h1234;
    step();
    wb_en = 1'b0;
    chk("fwd_ops", {id_rs_val, id_rd_val}, {16'h1234, 16'h1333});
    drive(1'b1, 16'h1260, 32'h134);
    step();
    chk("fwd_stored", id_rs_val, 16'h1234);

    // Stall holds ID/EX for 3 cycles; register write still lands
    drive(1'b1, 16'h0822, 32'h200);
    step();
    chk("pre_stall", {id_opcode, id_pc_next}, {5'h01, 32'h200});
    drive(1'b1, 16'h82E9, 32'h204);
    stall = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'hABCD;
    #1;
    chk("stall_ready", fetch.if_ready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      wb_en = 1'b0;
      chk($sformatf("stall%0d_hold", c), {id_valid, id_opcode, id_pc_next}, {1'b1, 5'h01, 32'h200});
    end
    stall = 1'b0;
    #1;
    chk("unstall_ready", fetch.if_ready, 1'b1);
    step();
    chk("unstall_emit", {id_opcode, id_pc_next}, {5'h10, 32'h204});
    chk("unstall_ops", {id_rs_val, id_rd_val}, {16'h1234, 16'h1777});
    drive(1'b1, 16'h1D00, 32'h208);
    step();
    chk("stall_wb", id_rs_val, 16'hABCD);

    // Flush wins over stall
    drive(1'b1, 16'h0822, 32'h210);
    stall = 1'b1;
    flush = 1'b1;
    step();
    chk("flush_stall_valid", id_valid, 1'b0);
    chk("flush_stall_ctrl", ctrl_now(), 4'b0000);
    stall = 1'b0;
    flush = 1'b0;

    // Flush in WAIT_IMM discards the pending LDD
    drive(1'b1, 16'hC8E0, 32'h300);
    step();
    chk("flush_ldd_bubble", id_valid, 1'b0);
    flush = 1'b1;
    drive(1'b1, 16'hBEEF, 32'h302);
    step();
    chk("flush_valid", id_valid, 1'b0);
    chk("flush_ctrl", ctrl_now(), 4'b0000);
    flush = 1'b0;
    drive(1'b1, 16'h0822, 32'h304);
    step();
    chk("post_flush_valid", id_valid, 1'b1);
    chk("post_flush_fields", {id_opcode, id_imm, id_pc_next}, {5'h01, 16'h0, 32'h304});
    chk("post_flush_ctrl", ctrl_now(), 4'b1000);

    // Async reset with a valid instruction in ID/EX
    drive(1'b0, 16'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step();
    rst_n = 1'b1;
    drive(1'b1, 16'h1D00, 32'h400);
    step();
    chk("rst_rf_cleared", {id_valid, id_rs_val}, {1'b1, 16'h0});

    // Async reset mid-WAIT_IMM loses the pending LDM
    drive(1'b1, 16'hC020, 32'h500);
    step();
    drive(1'b0, 16'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_wait");
    step();
    rst_n = 1'b1;
    drive(1'b1, 16'h0822, 32'h504);
    step();
    chk("post_rst_valid", id_valid, 1'b1);
    chk("post_rst_fields", {id_opcode, id_rd, id_shamt, id_imm, id_pc_next},
        {5'h01, 3'd1, 5'd2, 16'h0, 32'h504});
    chk("post_rst_ctrl", ctrl_now(), 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
